// File: rtl/hazard_stall_controller.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, stall/flush control,
// multi-cycle data-memory wait sequencing with timeout, and stall statistics.
module hazard_stall_controller #(
  parameter int RF_ADDR_WIDTH   = 5,
  parameter int MEM_TIMEOUT     = 16,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic [RF_ADDR_WIDTH-1:0]   i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0]   i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0]   i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0]   i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0]   i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0]   i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0]   i_WriteRegW,
  input  logic                       i_RegWriteE,
  input  logic                       i_RegWriteM,
  input  logic                       i_RegWriteW,
  input  logic [1:0]                 i_MemtoRegE,
  input  logic [1:0]                 i_MemtoRegM,
  input  logic                       i_BranchD,
  input  logic                       i_PCSrcD,
  input  logic                       i_DMemReqM,
  input  logic                       i_DMemAckM,
  output logic [1:0]                 o_ForwardAE,
  output logic [1:0]                 o_ForwardBE,
  output logic                       o_ForwardAD,
  output logic                       o_ForwardBD,
  output logic                       o_StallF,
  output logic                       o_StallD,
  output logic                       o_StallE,
  output logic                       o_StallM,
  output logic                       o_FlushD,
  output logic                       o_FlushE,
  output logic                       o_FlushW,
  output logic                       o_MemErr,
  output logic [STALL_CNT_WIDTH-1:0] o_StallCycles
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WC_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_e;

  state_e                     state_q, state_d;
  logic [WCW-1:0]             wait_cnt_q, wait_cnt_d;
  logic                       mem_err_q, mem_err_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic wre_nz, wrm_nz, wrw_nz;
  logic m_rse, w_rse, m_rte, w_rte;
  logic e_dep, m_dep;
  logic lwstall, branchstall, memstall;

  // Register 0 is hardwired, so it never creates a dependency
  assign wre_nz = |i_WriteRegE;
  assign wrm_nz = |i_WriteRegM;
  assign wrw_nz = |i_WriteRegW;

  assign m_rse = i_RegWriteM && wrm_nz && (i_WriteRegM == i_RsE);
  assign w_rse = i_RegWriteW && wrw_nz && (i_WriteRegW == i_RsE);
  assign m_rte = i_RegWriteM && wrm_nz && (i_WriteRegM == i_RtE);
  assign w_rte = i_RegWriteW && wrw_nz && (i_WriteRegW == i_RtE);

  assign o_ForwardAE = m_rse ? 2'b10 : (w_rse ? 2'b01 : 2'b00);
  assign o_ForwardBE = m_rte ? 2'b10 : (w_rte ? 2'b01 : 2'b00);

  assign o_ForwardAD = i_RegWriteM && wrm_nz && (i_WriteRegM == i_RsD);
  assign o_ForwardBD = i_RegWriteM && wrm_nz && (i_WriteRegM == i_RtD);

  assign e_dep = wre_nz &&
                 ((i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD));
  assign m_dep = wrm_nz &&
                 ((i_WriteRegM == i_RsD) || (i_WriteRegM == i_RtD));

  assign lwstall     = (i_MemtoRegE == 2'b01) && e_dep;
  assign branchstall = i_BranchD &&
                       ((i_RegWriteE && e_dep) ||
                        ((i_MemtoRegM == 2'b01) && m_dep));
  assign memstall    = (state_q == ERR) ||
                       (i_DMemReqM && !i_DMemAckM);

  always_comb begin
    o_StallF = 1'b0;
    o_StallD = 1'b0;
    o_StallE = 1'b0;
    o_StallM = 1'b0;
    o_FlushD = 1'b0;
    o_FlushE = 1'b0;
    o_FlushW = 1'b0;
    if (memstall) begin
      // Freeze F..M; Writeback drains and then takes bubbles
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_StallM = 1'b1;
      o_FlushW = 1'b1;
    end else if (lwstall || branchstall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_FlushE = 1'b1;
    end else begin
      o_FlushD = i_PCSrcD;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      IDLE: begin
        if (i_DMemReqM && !i_DMemAckM) begin
          state_d    = WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      WAIT: begin
        if (i_DMemAckM || !i_DMemReqM) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_MemErr      = mem_err_q;
  assign o_StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: per-cycle expected outputs
// are queued as stimulus is driven and checked mid-cycle.
module tb_hazard_stall_controller;

  logic       clk, rst;
  logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
  logic       rwe, rwm, rww;
  logic [1:0] mtre, mtrm;
  logic       br, pcsrc, req, ack;

  logic [1:0] fae, fbe;
  logic       fad, fbd, sf, sd, se, sm, fd, fe, fw, merr;
  logic [3:0] scyc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  exp_cnt;
  logic [17:0] exp_q[$];

  // {fae,fbe,fad,fbd,sf,sd,se,sm,fd,fe,fw}
  localparam logic [12:0] V0 = 13'd0;
  localparam logic [12:0] LU = {6'b0, 4'b1100, 3'b010};
  localparam logic [12:0] MS = {6'b0, 4'b1111, 3'b001};
  localparam logic [12:0] FD = {6'b0, 4'b0000, 3'b100};

  hazard_stall_controller #(
    .RF_ADDR_WIDTH(5),
    .MEM_TIMEOUT(16),
    .STALL_CNT_WIDTH(4)
  ) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_RsD(rsd), .i_RtD(rtd), .i_RsE(rse), .i_RtE(rte),
    .i_WriteRegE(wre), .i_WriteRegM(wrm), .i_WriteRegW(wrw),
    .i_RegWriteE(rwe), .i_RegWriteM(rwm), .i_RegWriteW(rww),
    .i_MemtoRegE(mtre), .i_MemtoRegM(mtrm),
    .i_BranchD(br), .i_PCSrcD(pcsrc),
    .i_DMemReqM(req), .i_DMemAckM(ack),
    .o_ForwardAE(fae), .o_ForwardBE(fbe),
    .o_ForwardAD(fad), .o_ForwardBD(fbd),
    .o_StallF(sf), .o_StallD(sd), .o_StallE(se), .o_StallM(sm),
    .o_FlushD(fd), .o_FlushE(fe), .o_FlushW(fw),
    .o_MemErr(merr), .o_StallCycles(scyc)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] fwd(input logic [1:0] a, b,
                                      input logic ad, bd);
    return {a, b, ad, bd, 7'b0};
  endfunction

  function automatic logic [17:0] obs();
    return {fae, fbe, fad, fbd, sf, sd, se, sm, fd, fe, fw, merr, scyc};
  endfunction

  task automatic clr_in();
    rsd = 0; rtd = 0; rse = 0; rte = 0;
    wre = 0; wrm = 0; wrw = 0;
    rwe = 0; rwm = 0; rww = 0;
    mtre = 0; mtrm = 0;
    br = 0; pcsrc = 0; req = 0; ack = 0;
  endtask

  // Counter model: a cycle expected to raise StallF bumps the count at its end
  task automatic push(input logic [12:0] vec, input logic err);
    exp_q.push_back({vec, err, exp_cnt});
    if (vec[6] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clr_in(); rst = 0; exp_cnt = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    logic [17:0] got, want;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; clr_in();
      case (i)
        0: begin rst = 0; push(V0, 1'b0); end
        1: begin
          rst = 0; rwm = 1; wrm = 5; rse = 5; rsd = 5;
          push(fwd(2'b10, 2'b00, 1'b1, 1'b0), 1'b0);
        end
        default: begin rst = 1; push(V0, 1'b0); end
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_forwarding();
    logic [17:0] got, want;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; clr_in();
      case (i)
        0: begin
          rwm = 1; wrm = 5; rww = 1; wrw = 5; rse = 5;
          push(fwd(2'b10, 2'b00, 1'b0, 1'b0), 1'b0);
        end
        1: begin
          rwm = 1; wrm = 7; rww = 1; wrw = 5; rse = 5;
          push(fwd(2'b01, 2'b00, 1'b0, 1'b0), 1'b0);
        end
        2: begin
          rwm = 1; wrm = 7; rww = 1; wrw = 5; rte = 7;
          push(fwd(2'b00, 2'b10, 1'b0, 1'b0), 1'b0);
        end
        3: begin
          rwm = 1; rww = 1;
          push(V0, 1'b0);
        end
        4: begin
          wrm = 5; rww = 1; wrw = 5; rse = 5; rte = 5;
          push(fwd(2'b01, 2'b01, 1'b0, 1'b0), 1'b0);
        end
        default: begin
          rwm = 1; wrm = 9; rsd = 9; rtd = 9;
          push(fwd(2'b00, 2'b00, 1'b1, 1'b1), 1'b0);
        end
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL fwd[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [17:0] got, want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; clr_in();
      case (i)
        0: begin
          mtre = 2'b01; rwe = 1; wre = 3; rte = 3; rsd = 3;
          push(LU, 1'b0);
        end
        1: begin
          rww = 1; wrw = 3; rse = 3;
          push(fwd(2'b01, 2'b00, 1'b0, 1'b0), 1'b0);
        end
        2: begin mtre = 2'b01; rwe = 1; push(V0, 1'b0); end
        default: push(V0, 1'b0);
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL loaduse[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_branch();
    logic [17:0] got, want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; clr_in();
      case (i)
        0: begin br = 1; rsd = 4; rwe = 1; wre = 4; push(LU, 1'b0); end
        1: begin
          br = 1; rsd = 4; mtrm = 2'b01; rwm = 1; wrm = 4;
          push(LU | fwd(2'b00, 2'b00, 1'b1, 1'b0), 1'b0);
        end
        2: begin
          br = 1; rsd = 4; pcsrc = 1; rww = 1; wrw = 4;
          push(FD, 1'b0);
        end
        3: push(V0, 1'b0);
        4: begin br = 1; rtd = 6; rwe = 1; wre = 5; push(V0, 1'b0); end
        default: begin rwe = 1; wre = 4; rsd = 4; push(V0, 1'b0); end
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL branch[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [17:0] got, want;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1; clr_in();
      if (i < 3) begin
        req = 1; push(MS, 1'b0);
      end else if (i == 3 || i == 4) begin
        req = 1; ack = 1; push(V0, 1'b0);
      end else if (i == 5) begin
        push(V0, 1'b0);
      end else if (i < 21) begin
        req = 1; push(MS, 1'b0);
      end else if (i == 21) begin
        req = 1; ack = 1; push(V0, 1'b0);
      end else if (i == 22 || i == 25) begin
        push(V0, 1'b0);
      end else begin
        req = 1; push(MS, 1'b0);
      end
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL memwait[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] got, want;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; clr_in();
      case (i)
        0, 1: begin
          req = 1; mtre = 2'b01; wre = 3; rsd = 3;
          push(MS, 1'b0);
        end
        2: begin
          req = 1; ack = 1; mtre = 2'b01; wre = 3; rsd = 3;
          push(LU, 1'b0);
        end
        3: push(V0, 1'b0);
        4: begin req = 1; br = 1; pcsrc = 1; push(MS, 1'b0); end
        5: begin req = 1; ack = 1; br = 1; pcsrc = 1; push(FD, 1'b0); end
        default: push(V0, 1'b0);
      endcase
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL b2b[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [17:0] got, want;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1; clr_in();
      if (i < 20) begin
        mtre = 2'b01; wre = 8; rtd = 8;
        push(LU, 1'b0);
      end else begin
        push(V0, 1'b0);
      end
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL sat[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [17:0] got, want;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1; clr_in();
      if (i < 16) begin
        req = 1; push(MS, 1'b0);
      end else if (i < 21) begin
        if (i == 18) begin req = 1; ack = 1; end
        push(MS, 1'b1);
      end else if (i == 21) begin
        rst = 0; exp_cnt = 0; push(V0, 1'b0);
      end else if (i == 22) begin
        rst = 1; push(V0, 1'b0);
      end else if (i == 23) begin
        req = 1; push(MS, 1'b0);
      end else begin
        req = 1; ack = 1; push(V0, 1'b0);
      end
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL timeout[%0d] got vec=%b err=%b cnt=%0d want vec=%b err=%b cnt=%0d",
                 i, got[17:5], got[4], got[3:0], want[17:5], want[4], want[3:0]);
      end
    end
  endtask

  initial begin
    clk = 0;
    rst = 0;
    exp_cnt = 0;
    clr_in();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_saturation();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
